// File: rtl/dac_waveform_sequencer_if.sv
// AXI-Stream beat bus: one frame per transfer, holding every channel's samples.
interface dac_waveform_sequencer_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TVALID;
  logic                  TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/dac_waveform_sequencer.sv
// Multi-channel waveform table player. First beat is valid 2 cycles after PLAY entry.
// Under TREADY backpressure the fetch/output pipeline stalls as a whole, so no beat is dropped.
module dac_waveform_sequencer #(
  parameter int NUM_CHANNELS       = 2,
  parameter int SAMPLE_WIDTH       = 16,
  parameter int SAMPLES_PER_BEAT   = 16,
  parameter int BEAT_ADDRESS_WIDTH = 10,
  parameter int COUNT_WIDTH        = 16
) (
  input  logic                                       sysClk,
  input  logic                                       sysReset,
  input  logic                                       tblWrEnable,
  input  logic [$clog2(NUM_CHANNELS)-1:0]            tblWrChannel,
  input  logic [BEAT_ADDRESS_WIDTH+$clog2(SAMPLES_PER_BEAT)-1:0] tblWrAddr,
  input  logic [SAMPLE_WIDTH-1:0]                    tblWrData,
  input  logic [NUM_CHANNELS*BEAT_ADDRESS_WIDTH-1:0] cfgLastIdx,
  input  logic [1:0]                                 cfgMode,
  input  logic [COUNT_WIDTH-1:0]                     cfgRepeat,
  input  logic                                       run,
  input  logic                                       trigger,
  input  logic                                       statusClear,
  dac_waveform_sequencer_if.master                   axis,
  output logic [1:0]                                 state,
  output logic                                       synced,
  output logic [COUNT_WIDTH-1:0]                     passCount,
  output logic                                       triggerMissed
);
  localparam int SMP_W     = $clog2(SAMPLES_PER_BEAT);
  localparam int TBL_AW    = BEAT_ADDRESS_WIDTH + SMP_W;
  localparam int TBL_DEPTH = 1 << TBL_AW;
  localparam int DATA_W    = NUM_CHANNELS * SAMPLES_PER_BEAT * SAMPLE_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, PLAY = 2'b10} seqState_t;
  seqState_t curState, nextState;

  logic [SAMPLE_WIDTH-1:0]       tbl [NUM_CHANNELS][TBL_DEPTH];
  logic [BEAT_ADDRESS_WIDTH-1:0] lastIdx [NUM_CHANNELS];
  logic [BEAT_ADDRESS_WIDTH-1:0] beatIdx [NUM_CHANNELS];
  logic                          modeSync, modeBurst;
  logic [COUNT_WIDTH-1:0]        repeatCnt, burstPass;
  logic                          fetchVld, fetchLast, outVld, outLast, nextIsZero;
  logic [DATA_W-1:0]             fetchDat, outDat;
  logic stall, accept, lastAccept, syncHit, startCfg, burstDone, syncTrig, flush;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) curState <= IDLE;
    else          curState <= nextState;
  end

  always_comb begin
    nextState  = curState;
    startCfg   = 1'b0;
    burstDone  = 1'b0;
    syncTrig   = 1'b0;
    flush      = 1'b0;
    stall      = outVld && !axis.TREADY;
    accept     = outVld && axis.TREADY;
    lastAccept = accept && outLast;
    // Index of the next beat channel 0 will hand over, including this cycle's transfer.
    syncHit    = accept ? outLast : nextIsZero;
    unique case (curState)
      IDLE: begin
        if (run) begin
          startCfg  = 1'b1;
          nextState = (cfgMode == 2'b10) ? ARMED : PLAY;
        end
      end
      ARMED: begin
        if (!run)         nextState = IDLE;
        else if (trigger) nextState = PLAY;
      end
      PLAY: begin
        if (!run) begin
          nextState = IDLE;
          flush     = 1'b1;
        end else if (modeBurst && lastAccept && burstPass == repeatCnt) begin
          nextState = ARMED;
          burstDone = 1'b1;
          flush     = 1'b1;
        end else if (modeSync && trigger) begin
          syncTrig = 1'b1;
          flush    = !syncHit;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Two-stage pipeline: table read register, then the AXIS output register.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      fetchVld   <= 1'b0;
      fetchLast  <= 1'b0;
      outVld     <= 1'b0;
      outLast    <= 1'b0;
      nextIsZero <= 1'b1;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) beatIdx[ch] <= '0;
    end else if (curState != PLAY || flush) begin
      fetchVld   <= 1'b0;
      outVld     <= 1'b0;
      nextIsZero <= 1'b1;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) beatIdx[ch] <= '0;
    end else if (!stall) begin
      fetchVld  <= 1'b1;
      fetchLast <= (beatIdx[0] == lastIdx[0]);
      outVld    <= fetchVld;
      outLast   <= fetchLast;
      if (accept) nextIsZero <= outLast;
      for (int ch = 0; ch < NUM_CHANNELS; ch++)
        beatIdx[ch] <= (beatIdx[ch] == lastIdx[ch]) ? '0
                                                     : beatIdx[ch] + BEAT_ADDRESS_WIDTH'(1);
    end
  end

  always_ff @(posedge sysClk) begin
    if (tblWrEnable && int'(tblWrChannel) < NUM_CHANNELS)
      tbl[tblWrChannel][tblWrAddr] <= tblWrData;
    if (curState == PLAY && !stall) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++)
        for (int s = 0; s < SAMPLES_PER_BEAT; s++)
          fetchDat[(ch*SAMPLES_PER_BEAT+s)*SAMPLE_WIDTH +: SAMPLE_WIDTH]
            <= tbl[ch][{beatIdx[ch], SMP_W'(s)}];
      outDat <= fetchDat;
    end
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) lastIdx[ch] <= '0;
      modeSync      <= 1'b0;
      modeBurst     <= 1'b0;
      repeatCnt     <= '0;
      burstPass     <= '0;
      passCount     <= '0;
      synced        <= 1'b0;
      triggerMissed <= 1'b0;
    end else begin
      if (startCfg) begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++)
          lastIdx[ch] <= cfgLastIdx[ch*BEAT_ADDRESS_WIDTH +: BEAT_ADDRESS_WIDTH];
        modeSync  <= (cfgMode == 2'b01);
        modeBurst <= (cfgMode == 2'b10);
        repeatCnt <= cfgRepeat;
      end
      if (startCfg)                              passCount <= '0;
      else if (lastAccept && passCount != '1)    passCount <= passCount + COUNT_WIDTH'(1);
      if (curState != PLAY)                      burstPass <= '0;
      else if (lastAccept && !burstDone)         burstPass <= burstPass + COUNT_WIDTH'(1);
      if (syncTrig)                              synced <= syncHit;
      else if (statusClear)                      synced <= 1'b0;
      if (curState == PLAY && modeBurst && trigger) triggerMissed <= 1'b1;
      else if (statusClear)                         triggerMissed <= 1'b0;
    end
  end

  assign state       = curState;
  assign axis.TDATA  = outDat;
  assign axis.TVALID = outVld;

endmodule

// File: tb/tb_dac_waveform_sequencer.sv
// Bench for dac_waveform_sequencer: expected beats come from a table model indexed n mod (lastIdx+1),
// queued by the stimulus and popped by an independent monitor on every accepted transfer.
module tb_dac_waveform_sequencer;
  localparam int NC  = 2;
  localparam int SW  = 16;
  localparam int SPB = 16;
  localparam int BAW = 10;
  localparam int CW  = 16;
  localparam int AW  = BAW + $clog2(SPB);
  localparam int DW  = NC * SPB * SW;
  localparam int FILL_BEATS = 16;

  logic              sysClk = 1'b0;
  logic              sysReset;
  logic              tblWrEnable;
  logic [0:0]        tblWrChannel;
  logic [AW-1:0]     tblWrAddr;
  logic [SW-1:0]     tblWrData;
  logic [NC*BAW-1:0] cfgLastIdx;
  logic [1:0]        cfgMode;
  logic [CW-1:0]     cfgRepeat;
  logic              run, trigger, statusClear;
  logic [1:0]        state;
  logic              synced, triggerMissed;
  logic [CW-1:0]     passCount;

  dac_waveform_sequencer_if #(.DATA_WIDTH(DW)) axis();

  dac_waveform_sequencer #(
    .NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW), .SAMPLES_PER_BEAT(SPB),
    .BEAT_ADDRESS_WIDTH(BAW), .COUNT_WIDTH(CW)
  ) dut (
    .sysClk(sysClk), .sysReset(sysReset),
    .tblWrEnable(tblWrEnable), .tblWrChannel(tblWrChannel),
    .tblWrAddr(tblWrAddr), .tblWrData(tblWrData),
    .cfgLastIdx(cfgLastIdx), .cfgMode(cfgMode), .cfgRepeat(cfgRepeat),
    .run(run), .trigger(trigger), .statusClear(statusClear),
    .axis(axis),
    .state(state), .synced(synced), .passCount(passCount), .triggerMissed(triggerMissed)
  );

  always #5 sysClk = ~sysClk;

  int total = 0;
  int bad   = 0;
  int acceptCnt = 0;
  int rdyLimit  = 0;
  bit rdyRandom = 1'b0;
  bit chkStable = 1'b0;
  logic [SW-1:0] model [NC][FILL_BEATS*SPB];
  logic [DW-1:0] expQ [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  function automatic logic [DW-1:0] beatOf(int i0, int i1);
    logic [DW-1:0] r;
    int idx [NC];
    idx[0] = i0;
    idx[1] = i1;
    r = '0;
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < SPB; s++)
        r[(c*SPB+s)*SW +: SW] = model[c][idx[c]*SPB+s];
    return r;
  endfunction

  task automatic pushSeq(int n, int l0, int l1);
    for (int k = 0; k < n; k++) expQ.push_back(beatOf(k % (l0+1), k % (l1+1)));
  endtask

  function automatic logic [NC*BAW-1:0] mkLast(int l0, int l1);
    logic [NC*BAW-1:0] r;
    r = '0;
    r[0 +: BAW]   = BAW'(l0);
    r[BAW +: BAW] = BAW'(l1);
    return r;
  endfunction

  task automatic waitAccepts(int target, int budget, string nm);
    int k = 0;
    while (acceptCnt < target && k < budget) begin
      cyc(1);
      k++;
    end
    chk(nm, acceptCnt, target);
  endtask

  task automatic waitState(logic [1:0] s, int budget, string nm);
    int k = 0;
    while (state !== s && k < budget) begin
      cyc(1);
      k++;
    end
    chk(nm, state, s);
  endtask

  // Waits until the beat with the given running number is on the bus (TREADY held high).
  task automatic waitBeat(int target, int budget, string nm);
    int  k = 0;
    bit  found = 1'b0;
    while (!found && k < budget) begin
      if (axis.TVALID === 1'b1 && acceptCnt == target) found = 1'b1;
      else begin
        cyc(1);
        k++;
      end
    end
    chk(nm, found, 1);
  endtask

  // Ready driver: stops granting exactly when the requested number of beats has been taken.
  initial begin
    axis.TREADY = 1'b0;
    forever begin
      @(posedge sysClk);
      #2;
      axis.TREADY = (acceptCnt < rdyLimit) && (!rdyRandom || $urandom_range(0, 1) == 1);
    end
  end

  // Monitor: sampled mid-cycle, so a valid&ready seen here completes at the next rising edge.
  initial begin
    logic          prevStall = 1'b0;
    logic [DW-1:0] prevDat   = '0;
    logic [DW-1:0] exp;
    forever begin
      @(negedge sysClk);
      if (chkStable && prevStall) begin
        total++;
        if (!(axis.TVALID === 1'b1 && axis.TDATA === prevDat)) begin
          bad++;
          $display("FAIL stable vld=%0b got=%h want=%h", axis.TVALID, axis.TDATA, prevDat);
        end
      end
      if (axis.TVALID === 1'b1 && axis.TREADY === 1'b1) begin
        acceptCnt++;
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL extra_beat n=%0d got=%h want=none", acceptCnt, axis.TDATA);
        end else begin
          exp = expQ.pop_front();
          if (axis.TDATA !== exp) begin
            bad++;
            $display("FAIL beat n=%0d got=%h want=%h", acceptCnt, axis.TDATA, exp);
          end
        end
      end
      prevStall = (axis.TVALID === 1'b1) && (axis.TREADY !== 1'b1);
      prevDat   = axis.TDATA;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    sysReset = 1'b1; run = 1'b0; trigger = 1'b0; statusClear = 1'b0;
    tblWrEnable = 1'b0; tblWrChannel = '0; tblWrAddr = '0; tblWrData = '0;
    cfgLastIdx = '0; cfgMode = 2'b00; cfgRepeat = '0;
    cyc(3);
    sysReset = 1'b0;
    cyc(1);
    chk("rst_state", state, 0);
    chk("rst_tvalid", axis.TVALID, 0);
    chk("rst_pass", passCount, 0);
    chk("rst_synced", synced, 0);
    chk("rst_missed", triggerMissed, 0);

    for (int c = 0; c < NC; c++)
      for (int b = 0; b < FILL_BEATS; b++)
        for (int s = 0; s < SPB; s++) begin
          tblWrEnable  = 1'b1;
          tblWrChannel = 1'(c);
          tblWrAddr    = AW'(b*SPB + s);
          tblWrData    = SW'($urandom);
          model[c][b*SPB+s] = tblWrData;
          cyc(1);
        end
    tblWrEnable = 1'b0;
    cyc(1);

    // FREE, lastIdx {3,1}, TREADY always high
    cfgLastIdx = mkLast(3, 1); cfgMode = 2'b00;
    pushSeq(12, 3, 1);
    rdyRandom = 1'b0; rdyLimit = acceptCnt + 12;
    run = 1'b1;
    cyc(1);
    chk("free_state", state, 2);
    chk("free_vld_t0", axis.TVALID, 0);
    cyc(1);
    chk("free_vld_t1", axis.TVALID, 0);
    cyc(1);
    chk("free_vld_t2", axis.TVALID, 1);
    waitAccepts(rdyLimit, 200, "free_beats");
    chk("free_pass", passCount, 3);
    cyc(1);
    chk("free_hold_vld", axis.TVALID, 1);
    run = 1'b0;
    cyc(1);
    chk("drop_vld", axis.TVALID, 0);
    chk("drop_state", state, 0);
    chk("free_q", expQ.size(), 0);

    // Restart with a new table length; channel 1 uses lastIdx 0
    cfgLastIdx = mkLast(1, 0);
    pushSeq(6, 1, 0);
    rdyLimit = acceptCnt + 6;
    run = 1'b1;
    cyc(1);
    chk("re_state", state, 2);
    cyc(1);
    chk("re_vld_t1", axis.TVALID, 0);
    cyc(1);
    chk("re_vld_t2", axis.TVALID, 1);
    waitAccepts(rdyLimit, 200, "re_beats");
    chk("re_pass", passCount, 3);
    run = 1'b0;
    cyc(2);
    chk("re_q", expQ.size(), 0);

    // FREE with random backpressure, lastIdx {5,2}
    cfgLastIdx = mkLast(5, 2);
    pushSeq(40, 5, 2);
    chkStable = 1'b1; rdyRandom = 1'b1; rdyLimit = acceptCnt + 40;
    run = 1'b1;
    waitAccepts(rdyLimit, 2000, "bp_beats");
    chk("bp_pass", passCount, 40 / 6);
    chkStable = 1'b0; rdyRandom = 1'b0;
    run = 1'b0;
    cyc(2);
    chk("bp_q", expQ.size(), 0);

    // BURST, lastIdx {2,1}, two passes per trigger
    cfgLastIdx = mkLast(2, 1); cfgMode = 2'b10; cfgRepeat = CW'(1);
    run = 1'b1;
    cyc(1);
    chk("burst_armed", state, 1);
    chk("burst_pass0", passCount, 0);
    base = acceptCnt;
    pushSeq(6, 2, 1);
    rdyRandom = 1'b1; rdyLimit = acceptCnt + 100;
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
    chk("burst_play", state, 2);
    cyc(3);
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
    chk("burst_missed", triggerMissed, 1);
    waitState(2'b01, 500, "burst_done_state");
    chk("burst_count", acceptCnt - base, 6);
    chk("burst_vld_low", axis.TVALID, 0);
    chk("burst_pass", passCount, 2);
    cyc(5);
    chk("burst_no_extra", acceptCnt - base, 6);
    statusClear = 1'b1;
    cyc(1);
    statusClear = 1'b0;
    chk("missed_clear", triggerMissed, 0);
    pushSeq(6, 2, 1);
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
    cyc(3);
    trigger = 1'b1; statusClear = 1'b1;
    cyc(1);
    trigger = 1'b0; statusClear = 1'b0;
    chk("missed_set_wins", triggerMissed, 1);
    waitState(2'b01, 500, "burst2_done_state");
    chk("burst2_count", acceptCnt - base, 12);
    chk("burst2_pass", passCount, 4);
    rdyRandom = 1'b0; rdyLimit = acceptCnt;
    run = 1'b0;
    cyc(2);
    chk("burst_q", expQ.size(), 0);

    // SYNC, lastIdx {7,3}: trigger on wrap, then trigger 3 beats into a period
    cfgLastIdx = mkLast(7, 3); cfgMode = 2'b01;
    for (int k = 0; k < 16; k++) expQ.push_back(beatOf(k % 8, k % 4));
    for (int k = 0; k < 3; k++)  expQ.push_back(beatOf(k, k));
    for (int k = 0; k < 8; k++)  expQ.push_back(beatOf(k, k % 4));
    base = acceptCnt;
    rdyLimit = acceptCnt + 27;
    run = 1'b1;
    waitBeat(base + 15, 200, "sync_wrap_beat");
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
    chk("sync_aligned", synced, 1);
    waitBeat(base + 18, 200, "sync_off_beat");
    trigger = 1'b1;
    cyc(1);
    trigger = 1'b0;
    chk("sync_offset", synced, 0);
    waitAccepts(base + 27, 300, "sync_beats");
    run = 1'b0;
    cyc(2);
    chk("sync_q", expQ.size(), 0);

    // Reset while a beat is stalled on the bus
    cfgLastIdx = mkLast(0, 0); cfgMode = 2'b00;
    pushSeq(3, 0, 0);
    rdyLimit = acceptCnt + 3;
    run = 1'b1;
    waitAccepts(rdyLimit, 200, "rst_pre_beats");
    cyc(2);
    chk("rst_pre_vld", axis.TVALID, 1);
    chk("rst_pre_pass", passCount, 3);
    sysReset = 1'b1;
    #1;
    chk("rst_mid_vld", axis.TVALID, 0);
    chk("rst_mid_state", state, 0);
    chk("rst_mid_pass", passCount, 0);
    run = 1'b0;
    cyc(2);
    sysReset = 1'b0;
    cyc(3);
    chk("rst_post_state", state, 0);
    chk("rst_post_vld", axis.TVALID, 0);
    chk("final_q", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
